// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word lines, single outstanding fill.
// A lookup that misses in IDLE latches the line address and moves to FETCH.
// FETCH holds iREN/iaddr steady until memory_control drops iwait, then writes
// the line and returns to IDLE so the retried request hits on the next cycle.
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [15:0] miss_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;

  // Request address fields; the byte offset is irrelevant for word fetches.
  logic [25:0] req_tag;
  logic [3:0]  req_idx;
  logic        unused_byte_offset;

  // Line address captured when the miss is detected, so the fill is immune
  // to the datapath changing or dropping its request while it waits.
  logic [25:0] fill_tag;
  logic [3:0]  fill_idx;

  // Storage: tag and data are never reset; the valid bits mask them.
  logic [31:0] data_arr [16];
  logic [25:0] tag_arr  [16];
  logic [15:0] valid;
  logic [15:0] miss_cnt;

  logic        lookup_hit;
  logic        miss_start;
  logic        fill_done;

  assign req_tag            = imemaddr[31:6];
  assign req_idx            = imemaddr[5:2];
  assign unused_byte_offset = ^imemaddr[1:0];

  assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  // Flush wins over everything, so it also suppresses starting or finishing a fill.
  assign miss_start = imemREN && (state == IDLE) && !lookup_hit && !flush;
  assign fill_done  = (state == FETCH) && !iwait && !flush;

  assign ihit       = imemREN && (state == IDLE) && lookup_hit && !flush;
  assign imemload   = data_arr[req_idx];
  assign miss_count = miss_cnt;

  // State register; reset abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory-side outputs; iaddr is parked at zero while idle.
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    case (state)
      IDLE: begin
        if (miss_start) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {fill_tag, fill_idx, 2'b00};
        if (!iwait) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (flush) begin
      next_state = IDLE;
    end
  end

  // Capture the missing line's address on the edge that enters FETCH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fill_tag <= '0;
      fill_idx <= '0;
    end else if (miss_start) begin
      fill_tag <= req_tag;
      fill_idx <= req_idx;
    end
  end

  // Valid bits and fill counter; flush clears both and discards a completing fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid    <= '0;
      miss_cnt <= '0;
    end else if (flush) begin
      valid    <= '0;
      miss_cnt <= '0;
    end else if (fill_done) begin
      valid[fill_idx] <= 1'b1;
      miss_cnt        <= miss_cnt + 16'd1;
    end
  end

  // Line write on fill completion; overwrites whatever tag was there before.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_arr[fill_idx] <= iload;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: one task per scenario, inline checks.
// Inputs are driven 1ns after the rising edge and outputs sampled before the next.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic [15:0] miss_count;

  int checks;
  int failures;

  icache dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .flush     (flush),
    .miss_count(miss_count)
  );

  // Free-running clock, 10ns period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so the run always ends even if something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Miss on addr, wait nwait cycles in FETCH, then complete the fill with data.
  task automatic do_fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    step();
    repeat (nwait) step();
    iwait = 1'b0;
    iload = data;
    step();
    iwait = 1'b1;
    iload = 32'h0;
  endtask

  task automatic do_reset();
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    flush    = 1'b0;
    step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iwait    = 1'b1;
    iload    = 32'h0;
    flush    = 1'b0;
    #1;
    checks++;
    if ({ihit, iREN, iaddr, miss_count} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ihit=%b iREN=%b iaddr=%h mc=%0d want 0 0 0 0",
               ihit, iREN, iaddr, miss_count);
    end
    step();
    nRST    = 1'b1;
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iwait    = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cold_miss_cycle0 got ihit=%b iREN=%b want 0 0", ihit, iREN);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
        failures++;
        $display("[TB] FAIL cold_miss_fetch%0d got iREN=%b iaddr=%h ihit=%b want 1 00000040 0",
                 c, iREN, iaddr, ihit);
      end
    end
    iwait = 1'b0;
    iload = 32'hDEADBEEF;
    step();
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hDEADBEEF || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL cold_miss_hit got ihit=%b load=%h mc=%0d want 1 deadbeef 1",
               ihit, imemload, miss_count);
    end
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL cold_miss_idle got iREN=%b iaddr=%h want 0 00000000", iREN, iaddr);
    end
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_conflict();
    do_reset();
    do_fill(32'h04, 32'hAAAA0004, 1);
    do_fill(32'h44, 32'hBBBB0044, 2);
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hBBBB0044) begin
      failures++;
      $display("[TB] FAIL conflict_new_hit got ihit=%b load=%h want 1 bbbb0044", ihit, imemload);
    end
    imemaddr = 32'h04;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL conflict_evicted got ihit=%b want 0", ihit);
    end
    do_fill(32'h04, 32'hCCCC0004, 0);
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hCCCC0004 || miss_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL conflict_refill got ihit=%b load=%h mc=%0d want 1 cccc0004 3",
               ihit, imemload, miss_count);
    end
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_hit_stream();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_fill(32'(i * 4), 32'h1000_0000 + 32'(i), i % 3);
    end
    for (int i = 0; i < 16; i++) begin
      imemREN  = 1'b1;
      imemaddr = 32'(i * 4);
      #1;
      checks++;
      if (ihit !== 1'b1 || imemload !== (32'h1000_0000 + 32'(i)) || iREN !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hit_stream_%0d got ihit=%b load=%h iREN=%b want 1 %h 0",
                 i, ihit, imemload, iREN, 32'h1000_0000 + 32'(i));
      end
      step();
    end
    checks++;
    if (miss_count !== 16'd16) begin
      failures++;
      $display("[TB] FAIL hit_stream_count got mc=%0d want 16", miss_count);
    end
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_mid_fill_change();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    iwait    = 1'b1;
    step();
    imemaddr = 32'h100;
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      failures++;
      $display("[TB] FAIL mid_fill_addr got iREN=%b iaddr=%h want 1 00000080", iREN, iaddr);
    end
    step();
    imemREN = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      failures++;
      $display("[TB] FAIL mid_fill_drop got iREN=%b iaddr=%h want 1 00000080", iREN, iaddr);
    end
    iwait = 1'b0;
    iload = 32'hCAFE0080;
    step();
    iwait    = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'hCAFE0080 || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL mid_fill_written got ihit=%b load=%h mc=%0d want 1 cafe0080 1",
               ihit, imemload, miss_count);
    end
    imemaddr = 32'h100;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_fill_other_miss got ihit=%b want 0", ihit);
    end
    step();
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h100) begin
      failures++;
      $display("[TB] FAIL mid_fill_next_fetch got iREN=%b iaddr=%h want 1 00000100", iREN, iaddr);
    end
    iwait = 1'b0;
    step();
    iwait   = 1'b1;
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_flush_collision();
    do_reset();
    do_fill(32'h08, 32'h0000_0808, 0);
    flush = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_masks_hit got ihit=%b want 0", ihit);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (ihit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_release_hit got ihit=%b want 1", ihit);
    end
    imemaddr = 32'h0C;
    step();
    iwait = 1'b0;
    iload = 32'h0BAD_0C0C;
    flush = 1'b1;
    step();
    flush   = 1'b0;
    iwait   = 1'b1;
    imemREN = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || miss_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL flush_collision_state got iREN=%b iaddr=%h mc=%0d want 0 0 0",
               iREN, iaddr, miss_count);
    end
    imemREN  = 1'b1;
    imemaddr = 32'h0C;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_discarded_fill got ihit=%b want 0", ihit);
    end
    imemaddr = 32'h08;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_cleared_line got ihit=%b want 0", ihit);
    end
    step();
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h08) begin
      failures++;
      $display("[TB] FAIL flush_next_miss got iREN=%b iaddr=%h want 1 00000008", iREN, iaddr);
    end
    iwait = 1'b0;
    step();
    iwait   = 1'b1;
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    do_fill(32'h10, 32'h0000_1010, 0);
    imemaddr = 32'h14;
    step();
    step();
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || miss_count !== 16'd0 || ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_now got iREN=%b iaddr=%h mc=%0d ihit=%b want 0 0 0 0",
               iREN, iaddr, miss_count, ihit);
    end
    iwait = 1'b0;
    iload = 32'hFFFF_1414;
    step();
    iwait = 1'b1;
    #2;
    nRST = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b0 || miss_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_line14 got ihit=%b mc=%0d want 0 0", ihit, miss_count);
    end
    imemaddr = 32'h10;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_line10 got ihit=%b want 0", ihit);
    end
    imemaddr = 32'h14;
    step();
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h14) begin
      failures++;
      $display("[TB] FAIL async_reset_remiss got iREN=%b iaddr=%h want 1 00000014", iREN, iaddr);
    end
    iwait = 1'b0;
    iload = 32'h0000_1414;
    step();
    iwait = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h0000_1414 || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL async_reset_refill got ihit=%b load=%h mc=%0d want 1 00001414 1",
               ihit, imemload, miss_count);
    end
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0200;
    iwait    = 1'b0;
    iload    = 32'h5A5A_0200;
    step();
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h200) begin
      failures++;
      $display("[TB] FAIL b2b_fetch got iREN=%b iaddr=%h want 1 00000200", iREN, iaddr);
    end
    step();
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h5A5A_0200 || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL b2b_min_latency got ihit=%b load=%h mc=%0d want 1 5a5a0200 1",
               ihit, imemload, miss_count);
    end
    imemaddr = 32'hFFFF_FFFC;
    iload    = 32'h7777_FFFC;
    step();
    step();
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h7777_FFFC || miss_count !== 16'd2) begin
      failures++;
      $display("[TB] FAIL b2b_top_addr got ihit=%b load=%h mc=%0d want 1 7777fffc 2",
               ihit, imemload, miss_count);
    end
    imemaddr = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== 32'h7777_FFFC) begin
      failures++;
      $display("[TB] FAIL b2b_byte_offset got ihit=%b load=%h want 1 7777fffc", ihit, imemload);
    end
    iwait   = 1'b1;
    imemREN = 1'b0;
    step();
  endtask

  // Scenario sequence and summary.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_hit_stream();
    test_mid_fill_change();
    test_flush_collision();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous, active-low reset.
REQ-003 imemREN  input  1  datapath instruction read request.
REQ-004 imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored.
REQ-005 ihit  output  1  requested word is valid in imemload this cycle.
REQ-006 imemload  output  32  instruction word to datapath.
REQ-007 iREN  output  1  read request to memory_control.
REQ-008 iaddr  output  32  word-aligned fill address to memory_control.
REQ-009 iwait  input  1  memory_control busy; low means iload is valid for iaddr.
REQ-010 iload  input  32  fill data from memory_control.
REQ-011 flush  input  1  synchronous invalidate-all request.
REQ-012 miss_count  output  16  number of completed fills since reset or flush.

Function
REQ-013 Organisation SHALL be direct-mapped, 16 lines, one 32-bit word per line, plus a valid bit and a 26-bit tag per line.
REQ-014 Address split SHALL be tag = imemaddr[31:6], index = imemaddr[5:2].
REQ-015 Hit SHALL be combinational: ihit = imemREN && state==IDLE && valid[index] && tag[index]==addr tag.
REQ-016 imemload SHALL equal data[index] combinationally in all states; it is meaningful only when ihit=1.
REQ-017 FSM SHALL have two states: IDLE and FETCH.
REQ-018 IDLE -> FETCH when imemREN=1 and the hit test fails; fill address {tag,index,2'b00} is latched on that edge.
REQ-019 IDLE SHALL hold state when imemREN=0 or on a hit; iREN=0 in IDLE.
REQ-020 In FETCH, iREN=1 and iaddr=latched fill address, held stable until the fill completes.
REQ-021 In FETCH with iwait=0, at the edge: data[fill index]<=iload, tag<=fill tag, valid<=1, miss_count+=1, state->IDLE.
REQ-022 In FETCH with iwait=1, state and arrays SHALL hold.
REQ-023 Latency: miss detected in cycle 0; iREN from cycle 1; hit is asserted the cycle after the first iwait=0 cycle; the minimum miss-to-hit time is 2 cycles.
REQ-024 A change or drop of imemREN/imemaddr during FETCH SHALL NOT abort the fill; the latched line is written.
REQ-025 A fill SHALL overwrite the indexed line unconditionally, evicting any prior tag.
REQ-026 flush=1 at an edge SHALL clear all valid bits, clear miss_count to 0, force state to IDLE, and discard any pending fill, including one completing in the same cycle; flush has priority over all other updates.
REQ-027 While flush=1, ihit SHALL be 0.
REQ-028 miss_count SHALL wrap modulo 2^16.
REQ-029 iaddr SHALL be 0 whenever state is IDLE.

Reset
REQ-030 nRST low SHALL immediately force: state=IDLE, all valid=0, miss_count=0, iREN=0, iaddr=0, and therefore ihit=0.
REQ-031 Tag and data arrays need not be reset; valid=0 masks them.
REQ-032 Reset asserted mid-FETCH SHALL abandon the fill with no line written; after release, the same request SHALL miss again.

Verification
REQ-033 Cold miss: reset, imemREN=1, imemaddr=0x00000040, with iwait low 3 cycles after iREN rises and iload=0xDEADBEEF. Required: iREN=1, iaddr=0x40 until the fill; the line is written; ihit=1 and imemload=0xDEADBEEF the next cycle; miss_count=1.
REQ-034 Conflict: fill 0x00000004, then request 0x00000044 (same index 1). Required: miss, refill, eviction; a re-request of 0x04 then misses; miss_count=3.
REQ-035 Hit stream: after filling indexes 0-15 at 0x00-0x3C, read all 16 again. Required: ihit=1 on each cycle, iREN=0 throughout, miss_count stays 16.
REQ-036 Request change mid-fill: miss on 0x80, then imemaddr changes to 0x100 while iwait=1. Required: iaddr stays 0x80, the line for 0x80 is written, and 0x100 then misses.
REQ-037 Flush collision: flush=1 in the same cycle iwait=0 during FETCH. Required: no valid line, state IDLE, miss_count=0, and the next request misses.
REQ-038 Async reset during FETCH at an arbitrary phase. Required: iREN=0 within the same cycle, no line valid after release, miss_count=0.
